// File: rtl/addsub_pipe_if.sv
// Handshake bundle for addsub_pipe. The slave modport is the arithmetic block.
// The master modport is the operand-select side plus the writeback side.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 36
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_signed;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_signed, in_sat, out_ready,
    input  in_ready, out_valid, out_res, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_signed, in_sat, out_ready,
    output in_ready, out_valid, out_res, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES registered chunks.
// Flags and saturation are resolved in the last stage, ahead of its register.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int unsigned CHUNK = (WIDTH + STAGES - 1) / STAGES;

  typedef struct packed {
    logic             v;
    logic             sub;
    logic             sgn;
    logic             sat;
    logic             c;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t           pipe_q [STAGES];
  stage_t           pipe_d [STAGES];
  stage_t           src    [STAGES];
  stage_t           last;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res;
  logic             stall;

  assign stall        = pipe_q[STAGES-1].v && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage 0 takes the ports, with b pre-inverted and carry-in = sub
  always_comb begin
    src[0]     = '0;
    src[0].v   = bus.in_valid;
    src[0].sub = bus.in_sub;
    src[0].sgn = bus.in_signed;
    src[0].sat = bus.in_sat;
    src[0].c   = bus.in_sub;
    src[0].a   = bus.in_a;
    src[0].b   = bus.in_sub ? ~bus.in_b : bus.in_b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = pipe_q[k-1];
    end
  end

  always_comb begin
    carry   = 1'b0;
    ovf     = 1'b0;
    sat_val = '0;
    res     = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      pipe_d[k] = src[k];
      carry     = src[k].c;
      // A stage whose chunk lies past WIDTH matches no bit and passes through
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i / CHUNK == k) begin
          pipe_d[k].s[i] = src[k].a[i] ^ src[k].b[i] ^ carry;
          carry = (src[k].a[i] & src[k].b[i]) | (carry & (src[k].a[i] ^ src[k].b[i]));
        end
      end
      pipe_d[k].c = carry;
    end

    last = pipe_d[STAGES-1];
    if (last.sgn) begin
      ovf     = (last.a[WIDTH-1] == last.b[WIDTH-1]) && (last.s[WIDTH-1] != last.a[WIDTH-1]);
      sat_val = last.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf     = last.sub ? !last.c : last.c;
      sat_val = last.sub ? '0 : '1;
    end
    res = (last.sat && ovf) ? sat_val : last.s;

    pipe_d[STAGES-1].s    = res;
    pipe_d[STAGES-1].ovf  = ovf;
    pipe_d[STAGES-1].zero = (res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign bus.out_valid = pipe_q[STAGES-1].v;
  assign bus.out_res   = pipe_q[STAGES-1].s;
  assign bus.out_cout  = pipe_q[STAGES-1].c;
  assign bus.out_ovf   = pipe_q[STAGES-1].ovf;
  assign bus.out_zero  = pipe_q[STAGES-1].zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe at WIDTH=36 with STAGES=2, 1 and 5.
// One DUT is selected at a time; the unselected ones idle with out_ready=1.
module tb_addsub_pipe;
  localparam int unsigned W = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;

  logic         tv = 1'b0, tsub = 1'b0, tsgn = 1'b0, tsat = 1'b0, tord = 1'b1;
  logic [W-1:0] ta = '0, tb_ = '0;

  addsub_pipe_if #(.WIDTH(W)) if0 ();
  addsub_pipe_if #(.WIDTH(W)) if1 ();
  addsub_pipe_if #(.WIDTH(W)) if2 ();

  assign if0.in_valid = tv && (sel == 0);
  assign if0.in_a = ta;  assign if0.in_b = tb_;  assign if0.in_sub = tsub;
  assign if0.in_signed = tsgn;  assign if0.in_sat = tsat;
  assign if0.out_ready = (sel == 0) ? tord : 1'b1;
  assign if1.in_valid = tv && (sel == 1);
  assign if1.in_a = ta;  assign if1.in_b = tb_;  assign if1.in_sub = tsub;
  assign if1.in_signed = tsgn;  assign if1.in_sat = tsat;
  assign if1.out_ready = (sel == 1) ? tord : 1'b1;
  assign if2.in_valid = tv && (sel == 2);
  assign if2.in_a = ta;  assign if2.in_b = tb_;  assign if2.in_sub = tsub;
  assign if2.in_signed = tsgn;  assign if2.in_sat = tsat;
  assign if2.out_ready = (sel == 2) ? tord : 1'b1;

  addsub_pipe #(.WIDTH(W), .STAGES(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(if0));
  addsub_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  addsub_pipe #(.WIDTH(W), .STAGES(5)) u_s5 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic         o_valid [3];
  logic         i_ready [3];
  logic         o_cout  [3];
  logic         o_ovf   [3];
  logic         o_zero  [3];
  logic [W-1:0] o_res   [3];

  assign o_valid[0] = if0.out_valid; assign i_ready[0] = if0.in_ready; assign o_res[0] = if0.out_res;
  assign o_cout[0]  = if0.out_cout;  assign o_ovf[0]   = if0.out_ovf;  assign o_zero[0] = if0.out_zero;
  assign o_valid[1] = if1.out_valid; assign i_ready[1] = if1.in_ready; assign o_res[1] = if1.out_res;
  assign o_cout[1]  = if1.out_cout;  assign o_ovf[1]   = if1.out_ovf;  assign o_zero[1] = if1.out_zero;
  assign o_valid[2] = if2.out_valid; assign i_ready[2] = if2.in_ready; assign o_res[2] = if2.out_res;
  assign o_cout[2]  = if2.out_cout;  assign o_ovf[2]   = if2.out_ovf;  assign o_zero[2] = if2.out_zero;

  function automatic int lat_for(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 5;
  endfunction

  // Issues one transaction on the selected DUT and waits (bounded) for its result.
  task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic sgn, input logic sat, output logic [W+2:0] got, output int lat);
    @(negedge clk);
    tv = 1'b1; ta = a; tb_ = b; tsub = sub; tsgn = sgn; tsat = sat; tord = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    lat = 1;
    while (!o_valid[sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {o_res[sel], o_cout[sel], o_ovf[sel], o_zero[sel]};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({o_valid[d], o_res[d], o_cout[d], o_ovf[d], o_zero[d]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: got v=%b res=%h c=%b o=%b z=%b, required all zero",
                 d, o_valid[d], o_res[d], o_cout[d], o_ovf[d], o_zero[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (i_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b required 1", i_ready[0]);
    end
  endtask

  task automatic test_basic();
    logic [W+2:0] got;
    int lat;
    sel = 0;
    run1(36'd5, 36'd3, 1'b0, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d required 2", lat); end
    n_cmp++;
    if (got !== {36'd8, 3'b000}) begin n_bad++; $display("FAIL add_5_3: got %h required %h", got, {36'd8, 3'b000}); end
    run1(36'd5, 36'd3, 1'b1, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL sub_latency: got %0d required 2", lat); end
    n_cmp++;
    if (got !== {36'd2, 3'b100}) begin n_bad++; $display("FAIL sub_5_3: got %h required %h", got, {36'd2, 3'b100}); end
  endtask

  task automatic test_carry_chain();
    logic [W+2:0] got;
    int lat;
    sel = 0;
    run1(36'h0_0003_FFFF, 36'd1, 1'b0, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {36'h0_0004_0000, 3'b000}) begin n_bad++; $display("FAIL chunk_carry: got %h required %h", got, {36'h0_0004_0000, 3'b000}); end
    run1(36'hF_FFFF_FFFF, 36'd1, 1'b0, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {36'h0, 3'b111}) begin n_bad++; $display("FAIL full_wrap: got %h required %h", got, {36'h0, 3'b111}); end
    run1(36'hF_FFFF_FFFF, 36'd2, 1'b0, 1'b0, 1'b1, got, lat);
    n_cmp++;
    if (got !== {36'hF_FFFF_FFFF, 3'b110}) begin n_bad++; $display("FAIL unsigned_add_sat: got %h required %h", got, {36'hF_FFFF_FFFF, 3'b110}); end
  endtask

  task automatic test_unsigned_borrow();
    logic [W+2:0] got;
    int lat;
    sel = 0;
    run1(36'd3, 36'd5, 1'b1, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {36'hF_FFFF_FFFE, 3'b010}) begin n_bad++; $display("FAIL borrow_wrap: got %h required %h", got, {36'hF_FFFF_FFFE, 3'b010}); end
    run1(36'd3, 36'd5, 1'b1, 1'b0, 1'b1, got, lat);
    n_cmp++;
    if (got !== {36'h0, 3'b011}) begin n_bad++; $display("FAIL borrow_sat: got %h required %h", got, {36'h0, 3'b011}); end
  endtask

  task automatic test_signed_overflow();
    logic [W+2:0] got;
    int lat;
    sel = 0;
    run1(36'h7_FFFF_FFFF, 36'd1, 1'b0, 1'b1, 1'b0, got, lat);
    n_cmp++;
    if (got !== {36'h8_0000_0000, 3'b010}) begin n_bad++; $display("FAIL signed_ovf_wrap: got %h required %h", got, {36'h8_0000_0000, 3'b010}); end
    run1(36'h7_FFFF_FFFF, 36'd1, 1'b0, 1'b1, 1'b1, got, lat);
    n_cmp++;
    if (got !== {36'h7_FFFF_FFFF, 3'b010}) begin n_bad++; $display("FAIL signed_sat_max: got %h required %h", got, {36'h7_FFFF_FFFF, 3'b010}); end
    run1(36'h8_0000_0000, 36'd1, 1'b1, 1'b1, 1'b1, got, lat);
    n_cmp++;
    if (got !== {36'h8_0000_0000, 3'b110}) begin n_bad++; $display("FAIL signed_sat_min: got %h required %h", got, {36'h8_0000_0000, 3'b110}); end
    run1(36'd2, 36'd5, 1'b1, 1'b1, 1'b1, got, lat);
    n_cmp++;
    if (got !== {36'hF_FFFF_FFFD, 3'b000}) begin n_bad++; $display("FAIL signed_no_ovf: got %h required %h", got, {36'hF_FFFF_FFFD, 3'b000}); end
  endtask

  task automatic test_other_depths();
    logic [W+2:0] got;
    int lat;
    sel = 1;
    run1(36'd5, 36'd3, 1'b1, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if ({lat[3:0], got} !== {4'd1, 36'd2, 3'b100}) begin n_bad++; $display("FAIL s1_sub: got lat=%0d %h required lat=1 %h", lat, got, {36'd2, 3'b100}); end
    sel = 2;
    run1(36'h0_FFFF_FFFF, 36'd1, 1'b0, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if ({lat[3:0], got} !== {4'd5, 36'h1_0000_0000, 3'b000}) begin n_bad++; $display("FAIL s5_carry: got lat=%0d %h required lat=5 %h", lat, got, {36'h1_0000_0000, 3'b000}); end
    sel = 0;
  endtask

  task automatic test_back_to_back(input int d);
    int           L, idx, got_n;
    logic [7:0]   mv;
    logic [W-1:0] q[$];
    logic         stall_m, acc;
    sel = d; L = lat_for(d); idx = 0; got_n = 0; mv = '0;
    tv = 1'b0; tord = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      tord = !(c >= 3 && c <= 6);
      if (idx < 6) begin
        tv = 1'b1; ta = 36'(1000 * idx + 7); tb_ = 36'(idx + 1);
        tsub = idx[0]; tsgn = 1'b0; tsat = 1'b0;
      end else begin
        tv = 1'b0;
      end
      #1;
      stall_m = mv[L-1] && !tord;
      n_cmp++;
      if (i_ready[d] !== !stall_m) begin n_bad++; $display("FAIL bp_in_ready dut%0d cyc%0d: got %b required %b", d, c, i_ready[d], !stall_m); end
      n_cmp++;
      if (o_valid[d] !== mv[L-1]) begin n_bad++; $display("FAIL bp_out_valid dut%0d cyc%0d: got %b required %b", d, c, o_valid[d], mv[L-1]); end
      if (o_valid[d]) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra dut%0d cyc%0d: got %h required no result", d, c, o_res[d]);
        end else if (o_res[d] !== q[0]) begin
          n_bad++; $display("FAIL bp_data dut%0d cyc%0d: got %h required %h", d, c, o_res[d], q[0]);
        end
        if (tord && q.size() > 0) begin
          void'(q.pop_front());
          got_n++;
        end
      end
      acc = tv && !stall_m;
      if (acc) begin
        q.push_back(tsub ? ta - tb_ : ta + tb_);
        idx++;
      end
      if (!stall_m) mv = {mv[6:0], acc};
      @(negedge clk);
    end
    tv = 1'b0; tord = 1'b1;
    n_cmp++;
    if (got_n !== 6 || q.size() !== 0) begin
      n_bad++; $display("FAIL bp_count dut%0d: got %0d delivered %0d pending, required 6 delivered 0 pending", d, got_n, q.size());
    end
    sel = 0;
  endtask

  task automatic test_reset_midflight();
    logic [W+2:0] got;
    int lat;
    sel = 0; tv = 1'b0; tord = 1'b1;
    repeat (2) @(negedge clk);
    tv = 1'b1; ta = 36'd11; tb_ = 36'd22; tsub = 1'b0; tsgn = 1'b0; tsat = 1'b0;
    @(negedge clk);
    ta = 36'd33; tb_ = 36'd44;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tv = 1'b0;
    n_cmp++;
    if ({o_valid[0], o_res[0]} !== '0) begin n_bad++; $display("FAIL midreset_clear: got v=%b res=%h required v=0 res=0", o_valid[0], o_res[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (i_ready[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b required 1", i_ready[0]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_stale cyc%0d: got out_valid=%b required 0", c, o_valid[0]); end
    end
    run1(36'd100, 36'd23, 1'b0, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if ({lat[3:0], got} !== {4'd2, 36'd123, 3'b000}) begin n_bad++; $display("FAIL midreset_new: got lat=%0d %h required lat=2 %h", lat, got, {36'd123, 3'b000}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_unsigned_borrow();
    test_signed_overflow();
    test_other_depths();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined adder/subtractor with valid/ready handshake, per-transaction add/sub select, signed/unsigned mode, optional saturation and result flags.
- Subtract is computed as a + ~b + 1 on one shared carry chain.
- The carry chain is split into STAGES registered chunks, so wide datapaths close timing.
- Sits in the arithmetic datapath between operand-select logic and result writeback.

Parameters:
- WIDTH, 36: operand and result width in bits; must be >= 2.
- STAGES, 2: pipeline depth and carry-chain chunk count; must satisfy 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts the input this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_sub  input  1  1: a - b; 0: a + b.
- in_signed  input  1  1: two's-complement overflow/saturation rules; 0: unsigned rules.
- in_sat  input  1  1: saturate on overflow; 0: wrap.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_res  output  WIDTH  result.
- out_cout  output  1  raw carry-out of the full-width sum.
- out_ovf  output  1  overflow or borrow occurred; independent of in_sat.
- out_zero  output  1  out_res == 0 after saturation.

Behaviour:
- Reset: asynchronous, active-low. Clears all stage valid bits immediately. out_valid=0, out_res=0, out_cout=0, out_ovf=0, out_zero=0.
- Reset mid-operation discards every in-flight transaction. in_ready=1 from the first cycle after reset deassertion.
- Handshakes: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_valid and out_ready only; no dependency on in_valid.
  - While stalled, all stage registers hold. No bubble squeezing.
  - When not stalled, every stage advances each cycle, and empty stages propagate valid=0.
- Latency: exactly STAGES cycles from input acceptance to out_valid when unstalled. Throughput is 1 per cycle.
- Chunking: CHUNK = ceil(WIDTH/STAGES).
  - Stage k (0-based) computes bits [k*CHUNK, min((k+1)*CHUNK, WIDTH)-1] using the carry registered from stage k-1. Stage 0 carry-in = in_sub.
  - b is inverted at input when in_sub=1.
  - Operand bits not yet consumed, completed lower result bits, and the control bits (sub/signed/sat) travel with the transaction.
  - If WIDTH is not divisible by STAGES, the last chunk is narrower. Any stage with an empty chunk passes data through.
- Flags, evaluated in the last stage on the raw sum s, with b' = in_sub ? ~b : b:
  - out_cout = carry-out of bit WIDTH-1.
  - Unsigned: ovf = in_sub ? !cout : cout.
  - Signed: ovf = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]).
- Saturation, applied when in_sat=1 and ovf=1, before the output register:
  - Unsigned add gives all-ones.
  - Unsigned sub gives 0.
  - Signed gives 0 followed by all-ones (max positive) if a[W-1]=0, else 1 followed by zeros (min negative).
- When in_sat=0 or ovf=0: out_res = s.
- out_ovf and out_cout always report the raw condition, whether or not saturation was applied.
- Output data fields are stable while out_valid && !out_ready.
- When out_valid=0, output data holds its last value; it carries no meaning.
- STAGES=1 degenerates to a single registered stage: latency 1, same handshake rules.

Test Plan:
- WIDTH=36, STAGES=2. a=5, b=3, add, unsigned, no sat. Expect res=8, cout=0, ovf=0, zero=0 exactly 2 cycles after acceptance. Then sub on the same operands: res=2, cout=1, ovf=0.
- Chunk-boundary carry (CHUNK=18): a=0x0_0003_FFFF, b=1, add. Expect res=0x0_0004_0000. Then a=0xF_FFFF_FFFF, b=1, add, unsigned, no sat. Expect res=0, cout=1, ovf=1, zero=1.
- Unsigned borrow: a=3, b=5, sub. With sat=0 expect res=0xF_FFFF_FFFE, ovf=1. With sat=1 expect res=0, ovf=1, zero=1.
- Signed overflow:
  - a=0x7_FFFF_FFFF, b=1, add, signed, sat=0: res=0x8_0000_0000, ovf=1.
  - Same with sat=1: res=0x7_FFFF_FFFF.
  - a=0x8_0000_0000, b=1, sub, signed, sat=1: res=0x8_0000_0000, ovf=1.
- Backpressure: 6 back-to-back inputs with out_ready=0 for cycles 3-6. Expect in_ready=0 exactly while out_valid && !out_ready, held outputs stable, all 6 results delivered in order with none lost or duplicated. Repeat with STAGES=1 and STAGES=5.
- Reset: assert rst_n=0 asynchronously mid-clock with 2 transactions in flight. Expect out_valid=0 immediately and no stale result after release. A new transaction then returns its result after exactly STAGES cycles.
